// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-control outputs of the pipeline controller
interface pipeline_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              ex_acc_start;
    logic              acc_done;
    logic              mem_busy;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              memwb_flush;
    logic [1:0]        ctrl_state;
    logic              acc_timeout;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_acc_start, acc_done, mem_busy,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush,
               ctrl_state, acc_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_acc_start, acc_done, mem_busy,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush,
               ctrl_state, acc_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline hazard/stall/flush controller
// Optional performance counters enabled by PIPECTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int REG_AW      = 5,
    parameter int ACC_TIMEOUT = 1024,
    parameter int CNT_W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ACC_WAIT = 2'd2
    } state_t;

    localparam int            TW    = $clog2(ACC_TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(ACC_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          acc_to_q, acc_to_d;

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              lu;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_fl, idex_fl, memwb_fl;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;
    assign lu  = bus.ex_mem_read && (rd != '0) &&
                 ((bus.id_use_rs1 && rs1 == rd) || (bus.id_use_rs2 && rs2 == rd));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            tcnt_q   <= '0;
            acc_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            acc_to_q <= acc_to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        acc_to_d = acc_to_q;
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        ifid_fl  = 1'b0;
        idex_fl  = 1'b0;
        memwb_fl = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.mem_busy) begin
                    state_d = MEM_WAIT;
                end else if (bus.ex_acc_start) begin
                    state_d = ACC_WAIT;
                    tcnt_d  = '0;
                end else if (bus.ex_branch_taken) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                end else if (lu) begin
                    // Bubble into ID/EX while IF/ID and PC hold the dependent instruction.
                    {idex_en, exmem_en, memwb_en} = 3'b111;
                    idex_fl = 1'b1;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_busy) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    state_d = RUN;
                end
            end
            ACC_WAIT: begin
                if (bus.acc_done || tcnt_q == TLAST) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    state_d = RUN;
                    if (!bus.acc_done) acc_to_d = 1'b1;
                end else begin
                    memwb_en = 1'b1;
                    memwb_fl = 1'b1;
                    tcnt_d   = tcnt_q + TW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.pc_en       = pc_en    & ~reset;
    assign bus.ifid_en     = ifid_en  & ~reset;
    assign bus.idex_en     = idex_en  & ~reset;
    assign bus.exmem_en    = exmem_en & ~reset;
    assign bus.memwb_en    = memwb_en & ~reset;
    assign bus.ifid_flush  = ifid_fl  & ~reset;
    assign bus.idex_flush  = idex_fl  & ~reset;
    assign bus.memwb_flush = memwb_fl & ~reset;
    assign bus.ctrl_state  = state_q;
    assign bus.acc_timeout = acc_to_q;

`ifdef PIPECTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            if (state_q == RUN && (ifid_fl || idex_fl) && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif
endmodule
